// File: rtl/fm_mix_pkg.sv
// fm_mix_pkg: shared widths, FSM state type and output saturation for the FM voice mixer.
package fm_mix_pkg;
  localparam int OUT_W = 16;
  localparam int N_VOICE = 8;
  localparam int VOICE_W = 24;
  localparam int GAIN_W = 8;
  localparam int TIMEOUT = 64;
  localparam int PW = VOICE_W + GAIN_W + 1;
  localparam int AW = PW + $clog2(N_VOICE);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, SAT, PUSH} state_e;
  function automatic logic [OUT_W-1:0] sat_shift(input logic signed [AW-1:0] acc);
    logic signed [AW-1:0] s;
    s = acc >>> GAIN_W;
    return (&s[AW-1:OUT_W-1] || ~|s[AW-1:OUT_W-1]) ? s[OUT_W-1:0]
         : s[AW-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
  endfunction
endpackage

// File: rtl/fm_mix_acc.sv
// fm_mix_acc: one channel's signed sample x unsigned gain multiply-accumulate.
//   clk_i/rst_i clock and sync reset, clr_i zeroes the sum, en_i adds sample_i*gain_i,
//   acc_o is the running signed sum.
module fm_mix_acc
  import fm_mix_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clr_i,
  input  logic               en_i,
  input  logic [VOICE_W-1:0] sample_i,
  input  logic [GAIN_W-1:0]  gain_i,
  output logic [AW-1:0]      acc_o
);
  logic signed [PW-1:0] prod;
  logic signed [AW-1:0] acc_q, acc_d;
  always_comb begin
    prod = $signed(sample_i) * $signed({1'b0, gain_i});
    acc_d = clr_i ? '0 : en_i ? acc_q + AW'(prod) : acc_q;
  end
  always_ff @(posedge clk_i) acc_q <= rst_i ? '0 : acc_d;
  assign acc_o = acc_q;
endmodule

// File: rtl/fm_voice_mixer.sv
// fm_voice_mixer: polls NV FM voices per sample request, mixes them to a saturated stereo FIFO word.
//   FCLK/Reset clock and sync reset; sampGenEn/fifoFull start request and FIFO backpressure;
//   voiceReq/voiceIdx poll a voice, voiceValid/voiceSample/voiceGainL/voiceGainR answer it;
//   sampOut/sampWr FIFO write; busy is high outside IDLE; timeoutErr is a sticky voice-timeout flag.
module fm_voice_mixer
  import fm_mix_pkg::*;
#(
  parameter int DW = 2 * OUT_W,
  parameter int OW = OUT_W,
  parameter int NV = N_VOICE,
  parameter int VW = VOICE_W,
  parameter int GW = GAIN_W,
  parameter int TO = TIMEOUT
) (
  input  logic                  FCLK,
  input  logic                  Reset,
  input  logic                  sampGenEn,
  input  logic                  fifoFull,
  output logic [DW-1:0]         sampOut,
  output logic                  sampWr,
  output logic                  voiceReq,
  output logic [$clog2(NV)-1:0] voiceIdx,
  input  logic                  voiceValid,
  input  logic [VW-1:0]         voiceSample,
  input  logic [GW-1:0]         voiceGainL,
  input  logic [GW-1:0]         voiceGainR,
  output logic                  busy,
  output logic                  timeoutErr
);
  localparam int IW = $clog2(NV);
  localparam int CW = $clog2(TO);
  state_e state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] samp_q, samp_d;
  logic terr_q, terr_d;
  logic start, in_wait, tmo, take, last;
  logic [AW-1:0] acc_l, acc_r;
  // A timed-out voice advances the FSM exactly like a valid one but adds nothing.
  always_comb begin
    start = state_q == IDLE && sampGenEn && !fifoFull;
    in_wait = state_q == WAIT;
    tmo = in_wait && !voiceValid && cnt_q == CW'(TO - 1);
    take = in_wait && (voiceValid || tmo);
    last = idx_q == IW'(NV - 1);
  end
  always_ff @(posedge FCLK) state_q <= Reset ? IDLE : state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = start ? REQ : IDLE;
      REQ:  state_d = WAIT;
      WAIT: state_d = !take ? WAIT : last ? SAT : REQ;
      SAT:  state_d = PUSH;
      PUSH: state_d = fifoFull ? PUSH : IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    voiceReq = state_q == REQ;
    busy = state_q != IDLE;
    sampWr = state_q == PUSH && !fifoFull;
  end
  always_comb begin
    idx_d = start ? '0 : (take && !last) ? idx_q + 1'b1 : idx_q;
    cnt_d = (in_wait && !take) ? cnt_q + 1'b1 : '0;
    terr_d = terr_q | tmo;
    samp_d = state_q == SAT ? {sat_shift(acc_l), sat_shift(acc_r)} : samp_q;
  end
  always_ff @(posedge FCLK) begin
    if (Reset) begin
      idx_q <= '0;
      cnt_q <= '0;
      samp_q <= '0;
      terr_q <= 1'b0;
    end else begin
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      samp_q <= samp_d;
      terr_q <= terr_d;
    end
  end
  fm_mix_acc u_acc_l (
    .clk_i(FCLK), .rst_i(Reset), .clr_i(start), .en_i(in_wait && voiceValid),
    .sample_i(voiceSample), .gain_i(voiceGainL), .acc_o(acc_l)
  );
  fm_mix_acc u_acc_r (
    .clk_i(FCLK), .rst_i(Reset), .clr_i(start), .en_i(in_wait && voiceValid),
    .sample_i(voiceSample), .gain_i(voiceGainR), .acc_o(acc_r)
  );
  assign sampOut = samp_q;
  assign voiceIdx = idx_q;
  assign timeoutErr = terr_q;
endmodule

// File: tb/tb_fm_voice_mixer.sv
// tb_fm_voice_mixer: directed frames checked against an arithmetic mixing model.
module tb_fm_voice_mixer;
  logic FCLK = 0, Reset = 1, sampGenEn = 0, fifoFull = 0, voiceValid = 0;
  logic [31:0] sampOut;
  logic sampWr, voiceReq, busy, timeoutErr;
  logic [2:0] voiceIdx;
  logic [23:0] voiceSample = '0;
  logic [7:0] voiceGainL = '0, voiceGainR = '0;
  int checks = 0, failures = 0;
  int vs[8], gl[8], gr[8];
  bit miss[8];
  logic [31:0] exp_samp = '0, last = '0;
  logic m_terr = 0;
  int exp_idx = 0, wr_cnt = 0;

  fm_voice_mixer dut (
    .FCLK(FCLK), .Reset(Reset), .sampGenEn(sampGenEn), .fifoFull(fifoFull),
    .sampOut(sampOut), .sampWr(sampWr), .voiceReq(voiceReq), .voiceIdx(voiceIdx),
    .voiceValid(voiceValid), .voiceSample(voiceSample), .voiceGainL(voiceGainL),
    .voiceGainR(voiceGainR), .busy(busy), .timeoutErr(timeoutErr)
  );

  always #5 FCLK = ~FCLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] clamp(input longint a);
    longint b;
    b = a >>> 8;
    if (b > 32767) return 16'h7FFF;
    if (b < -32768) return 16'h8000;
    return 16'(b);
  endfunction

  function automatic logic [31:0] model();
    longint al = 0, ar = 0;
    for (int i = 0; i < 8; i++)
      if (!miss[i]) begin
        al += longint'(vs[i]) * gl[i];
        ar += longint'(vs[i]) * gr[i];
      end
    return {clamp(al), clamp(ar)};
  endfunction

  function automatic bit any_miss();
    for (int i = 0; i < 8; i++) if (miss[i]) return 1;
    return 0;
  endfunction

  task automatic set_all(input int s, input int l, input int r);
    for (int i = 0; i < 8; i++) begin vs[i] = s; gl[i] = l; gr[i] = r; miss[i] = 0; end
  endtask

  // Voice source: answers each request in the first WAIT cycle; outside a poll it
  // drives a junk valid that the mixer must ignore. A missing voice never answers.
  initial begin
    bit prev = 0, mc = 0;
    forever begin
      @(posedge FCLK); #1;
      if (voiceReq) begin
        voiceSample = 24'(vs[voiceIdx]);
        voiceGainL = 8'(gl[voiceIdx]);
        voiceGainR = 8'(gr[voiceIdx]);
        voiceValid = !miss[voiceIdx];
        mc = miss[voiceIdx];
      end else if (!prev) begin
        voiceValid = !mc;
        voiceSample = 24'h7FFFFF;
        voiceGainL = 8'hFF;
        voiceGainR = 8'hFF;
      end
      prev = voiceReq;
    end
  end

  // Per-cycle compare against the model.
  initial forever begin
    @(negedge FCLK);
    if (!Reset) begin
      if (sampWr) begin
        chk("sampOut", sampOut, exp_samp);
        last = exp_samp;
        wr_cnt++;
      end
      if (!busy) begin
        chk("idle_hold", sampOut, last);
        chk("timeoutErr", timeoutErr, m_terr);
      end
      if (voiceReq) begin
        chk("req_idx", voiceIdx, exp_idx);
        exp_idx = (exp_idx + 1) % 8;
      end
      if (fifoFull) chk("wr_while_full", sampWr, 0);
    end
  end

  task automatic frame(input bit chk_lat);
    int n;
    exp_samp = model();
    exp_idx = 0;
    sampGenEn = 1;
    @(posedge FCLK); #1;
    sampGenEn = 0;
    n = 1;
    while (!sampWr && n < 300) begin @(posedge FCLK); #1; n++; end
    chk("wr_seen", sampWr, 1);
    if (chk_lat) chk("latency", n, 18);
    if (any_miss()) m_terr = 1;
    @(posedge FCLK); #1;
    chk("one_pulse", sampWr, 0);
    chk("back_idle", busy, 0);
  endtask

  initial begin
    int n, t1, t2, w0;
    logic [31:0] m;
    set_all(0, 0, 0);
    repeat (3) @(posedge FCLK);
    #1;
    chk("rst_sampOut", sampOut, 0);
    chk("rst_sampWr", sampWr, 0);
    chk("rst_voiceReq", voiceReq, 0);
    chk("rst_voiceIdx", voiceIdx, 0);
    chk("rst_busy", busy, 0);
    chk("rst_terr", timeoutErr, 0);
    Reset = 0;
    @(posedge FCLK); #1;

    vs[0] = 1000; gl[0] = 128; gr[0] = 255;
    chk("model_single", model(), 32'h01F4_03E4);
    frame(1);
    vs[0] = -1000; gl[0] = 128; gr[0] = 128;
    chk("model_neg", model(), 32'hFE0C_FE0C);
    frame(1);
    set_all(24'h100000, 255, 0);
    chk("model_sat_pos", model(), 32'h7FFF_0000);
    frame(1);
    set_all(-24'h100000, 255, 0);
    m = model();
    chk("model_sat_neg", m[31:16], 16'h8000);
    frame(1);
    chk("sat_neg_out", sampOut[31:16], 16'h8000);

    set_all(1000, 128, 128);
    miss[3] = 1;
    chk("model_timeout", model(), 32'h0DAC_0DAC);
    frame(0);
    chk("terr_set", timeoutErr, 1);
    miss[3] = 0;
    frame(1);
    chk("terr_sticky", timeoutErr, 1);

    set_all(300, 20, 40);
    exp_samp = model();
    exp_idx = 0;
    sampGenEn = 1;
    n = 0; t1 = 0; t2 = 0;
    while (t2 == 0 && n < 100) begin
      @(posedge FCLK); #1; n++;
      if (sampWr) begin
        if (t1 == 0) t1 = n; else begin t2 = n; sampGenEn = 0; end
      end
    end
    sampGenEn = 0;
    chk("b2b_first", t1, 18);
    chk("b2b_second", t2, 37);
    @(posedge FCLK); #1;
    chk("b2b_idle", busy, 0);

    set_all(0, 0, 0);
    vs[5] = -7000; gl[5] = 200; gr[5] = 3;
    exp_samp = model();
    exp_idx = 0;
    fifoFull = 1;
    sampGenEn = 1;
    repeat (5) begin @(posedge FCLK); #1; chk("no_start_full", busy, 0); end
    fifoFull = 0;
    w0 = wr_cnt;
    n = 0;
    repeat (17) begin @(posedge FCLK); #1; n++; if (n == 1) sampGenEn = 0; end
    fifoFull = 1;
    repeat (10) begin @(posedge FCLK); #1; chk("bp_no_wr", sampWr, 0); chk("bp_busy", busy, 1); end
    fifoFull = 0;
    #1;
    chk("bp_wr", sampWr, 1);
    @(posedge FCLK); #1;
    chk("bp_single", sampWr, 0);
    chk("bp_idle", busy, 0);
    chk("bp_count", wr_cnt - w0, 1);

    set_all(5000, 255, 255);
    exp_idx = 0;
    sampGenEn = 1;
    @(posedge FCLK); #1;
    sampGenEn = 0;
    n = 0;
    while (!(busy && !voiceReq && voiceIdx == 4) && n < 100) begin @(posedge FCLK); #1; n++; end
    chk("reached_v4", voiceIdx, 4);
    w0 = wr_cnt;
    Reset = 1;
    @(posedge FCLK); #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_sampOut", sampOut, 0);
    chk("mid_rst_idx", voiceIdx, 0);
    chk("mid_rst_req", voiceReq, 0);
    chk("mid_rst_terr", timeoutErr, 0);
    m_terr = 0;
    last = 0;
    Reset = 0;
    repeat (25) @(posedge FCLK);
    #1;
    chk("mid_rst_no_wr", wr_cnt - w0, 0);
    for (int i = 0; i < 8; i++) begin vs[i] = 100 * (i + 1) - 350; gl[i] = 10 * i; gr[i] = 250 - 7 * i; end
    frame(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
